maze_move_ctrl: RTL and testbench
=================================

# maze_move_ctrl

Sequences player movement in the maze game. Converts the 4-bit button vector into single-cell move requests with hold-to-repeat. Each candidate cell is checked through a 1-bit wall-map ROM read port, and the move is committed only if the cell is free. Also owns the move counter, the "game running" enable for the elapsed-time counter, and end-cell detection. Sits between the board buttons, port B of the maze ROM, and the VGA/timer logic in the top level.

## Interface
Parameters:
- MAZE_W, 48, maze width in cells
- MAZE_H, 48, maze height in cells
- ADDR_W, 12, ROM address width; MAZE_W*MAZE_H ≤ 2^ADDR_W
- START_X, 1, reset column
- START_Y, 1, reset row
- END_ADDR, 2110, linear address of goal cell
- ROM_LAT, 1, ROM read latency in clk cycles (≥1)
- REPEAT_CYCLES, 12500000, hold-to-repeat period in clk cycles (≥2)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- mov  in  4  buttons, active-high: [0] up, [1] down, [2] left, [3] right
- rom_addr  out  ADDR_W  wall-map read address
- rom_q  in  1  wall-map data, 1 = wall
- pos_x  out  10  committed column
- pos_y  out  10  committed row
- move_cnt  out  16  accepted moves, saturating
- running  out  1  timer enable
- done  out  1  goal reached
- busy  out  1  move check in progress

## Operation
- FSM states: IDLE, ADDR, WAIT, CHECK, DONE.
- Direction priority when several mov bits are set: up > down > left > right.
- held register: last issued mov pattern. Cleared to 0 in any cycle where mov == 0.
- rep_cnt: counts cycles while in IDLE with mov == held ≠ 0. Cleared on each issue.
- Issue condition in IDLE: mov ≠ 0 and (mov ≠ held or rep_cnt == REPEAT_CYCLES-1). On issue, latch direction, held ← mov.
- Boundary moves are rejected directly, no ROM access, stay in IDLE: up at y=0, down at y=MAZE_H-1, left at x=0, right at x=MAZE_W-1.
- Otherwise, compute the candidate (cx,cy) and go to ADDR.
- Address = x + y*MAZE_W, computed at ADDR_W width with no truncation.
- In IDLE, rom_addr = address of the committed position.
- In ADDR/WAIT/CHECK, rom_addr = candidate address, registered and held stable.
- ADDR lasts 1 cycle. WAIT lasts ROM_LAT-1 cycles (skipped if ROM_LAT=1). CHECK samples rom_q.
- In CHECK:
  - rom_q=1: discard the candidate and return to IDLE.
  - rom_q=0: commit pos ← candidate, increment move_cnt (saturates at 0xFFFF), set running ← 1.
  - If the candidate address == END_ADDR, go to DONE, else IDLE.
- DONE: running=0, done=1, mov ignored, rom_addr = END_ADDR. Exit only via rst.
- mov activity while busy does not queue moves; only held-clearing applies.
- busy = 1 in ADDR, WAIT, CHECK.

## Timing
- Reset values: pos = (START_X, START_Y), rom_addr = START_X + START_Y*MAZE_W, move_cnt=0, running=0, done=0, busy=0, held=0, rep_cnt=0, state IDLE.
- Issue sampled at cycle 0: ADDR and busy at cycle 1, CHECK at cycle 1+ROM_LAT, new pos/move_cnt/running/done visible at cycle 2+ROM_LAT (3 for ROM_LAT=1).
- Boundary reject: no state change; busy stays 0.
- Repeat: while held, moves issue every REPEAT_CYCLES IDLE cycles after returning from CHECK.
- rst in any state, including WAIT/CHECK, restores all reset values next cycle. The in-flight move is dropped.
- All outputs registered; no combinational path from mov or rom_q to any output.

## Structure
- Shared package maze_pkg:
  - direction index constants (DIR_UP=0 … DIR_RIGHT=3)
  - FSM state enum
  - MAZE_W, MAZE_H, ADDR_W, END_ADDR defaults, shared with the top level and renderer
- One sub-module: maze_key_repeat. It holds held/rep_cnt and outputs a one-cycle issue pulse plus the priority-encoded direction. It gets an enable input so it only counts in IDLE.

## Test plan
- Reset → pos=(1,1), rom_addr=49, move_cnt=0, running=0, done=0, busy=0.
- ROM cell 50 = 0; pulse mov=4'b1000 for 1 cycle → rom_addr=50 at cycle 1, pos=(2,1) at cycle 3, move_cnt=1, running=1.
- ROM cell 50 = 1; mov=4'b1000 → busy 2 cycles, pos stays (1,1), move_cnt=0, running=0.
- START_X=0; mov=4'b0100 → busy never asserts, rom_addr stays 48, pos unchanged.
- REPEAT_CYCLES=8, free corridor, hold mov=4'b1000 for 40 cycles → first move at cycle 3, then one commit every 8+2 cycles; release → no further moves.
- Walk onto cell 2110 → done=1, running=0 at commit cycle; later mov has no effect. rst asserted during WAIT (ROM_LAT=3) → reset values next cycle, no commit.

Source files
------------

// File: rtl/maze_pkg.sv
// maze_pkg: constants and types shared by the maze movement controller,
// the top level and the renderer.
//   - DEF_* : default maze geometry, ROM address width and goal cell
//   - DIR_* : direction indices, matching bit positions of the mov buttons
//   - move_state_t : movement controller FSM states
package maze_pkg;

    localparam int DEF_MAZE_W   = 48;
    localparam int DEF_MAZE_H   = 48;
    localparam int DEF_ADDR_W   = 12;
    localparam int DEF_END_ADDR = 2110;

    localparam int DIR_UP    = 0;
    localparam int DIR_DOWN  = 1;
    localparam int DIR_LEFT  = 2;
    localparam int DIR_RIGHT = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_CHECK,
        S_DONE
    } move_state_t;

endpackage

// File: rtl/maze_key_repeat.sv
// maze_key_repeat: turns the raw button vector into single move requests
// with hold-to-repeat.
//   clk, rst : system clock, synchronous active-high reset
//   en       : controller is idle and may accept a move (repeat only counts here)
//   mov      : buttons [0] up, [1] down, [2] left, [3] right
//   issue    : one-cycle request for a move this cycle
//   dir      : priority-encoded direction (up > down > left > right)
module maze_key_repeat
    import maze_pkg::*;
#(
    parameter int REPEAT_CYCLES = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] mov,
    output logic       issue,
    output logic [1:0] dir
);

    localparam int               CNT_W    = $clog2(REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic [3:0]       held;
    logic [CNT_W-1:0] rep_cnt;

    // A new pattern issues at once; an unchanged held pattern issues only
    // when the repeat period has elapsed.
    always_comb begin
        issue = en && (mov != 4'd0) && ((mov != held) || (rep_cnt == CNT_LAST));
    end

    always_comb begin
        if (mov[DIR_UP])        dir = 2'(DIR_UP);
        else if (mov[DIR_DOWN]) dir = 2'(DIR_DOWN);
        else if (mov[DIR_LEFT]) dir = 2'(DIR_LEFT);
        else                    dir = 2'(DIR_RIGHT);
    end

    // Releasing all buttons clears held even while a move is in flight, so
    // a quick re-press after the check counts as a fresh press.
    always_ff @(posedge clk) begin
        if (rst) begin
            held    <= 4'd0;
            rep_cnt <= '0;
        end else if (mov == 4'd0) begin
            held    <= 4'd0;
            rep_cnt <= '0;
        end else if (issue) begin
            held    <= mov;
            rep_cnt <= '0;
        end else if (en && (mov == held)) begin
            rep_cnt <= rep_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/maze_move_ctrl.sv
// maze_move_ctrl: sequences player movement through the maze.
//   clk, rst  : system clock, synchronous active-high reset
//   mov       : buttons [0] up, [1] down, [2] left, [3] right
//   rom_addr  : wall-map read address (committed cell when idle,
//               candidate cell during a check, goal cell when done)
//   rom_q     : wall-map data, 1 = wall, ROM_LAT cycles after rom_addr
//   pos_x/y   : committed position
//   move_cnt  : accepted moves, saturating
//   running   : elapsed-time counter enable
//   done      : goal reached, sticky until reset
//   busy      : a move check is in progress
module maze_move_ctrl
    import maze_pkg::*;
#(
    parameter int MAZE_W        = DEF_MAZE_W,
    parameter int MAZE_H        = DEF_MAZE_H,
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int START_X       = 1,
    parameter int START_Y       = 1,
    parameter int END_ADDR      = DEF_END_ADDR,
    parameter int ROM_LAT       = 1,
    parameter int REPEAT_CYCLES = 12500000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        mov,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_q,
    output logic [9:0]        pos_x,
    output logic [9:0]        pos_y,
    output logic [15:0]       move_cnt,
    output logic              running,
    output logic              done,
    output logic              busy
);

    localparam int                WAIT_W    = (ROM_LAT > 2) ? $clog2(ROM_LAT - 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((ROM_LAT > 1) ? ROM_LAT - 2 : 0);
    localparam logic [ADDR_W-1:0] END_A     = ADDR_W'(END_ADDR);
    localparam logic [9:0]        START_XV  = 10'(START_X);
    localparam logic [9:0]        START_YV  = 10'(START_Y);

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [9:0] x, input logic [9:0] y);
        return ADDR_W'(x) + ADDR_W'(y) * ADDR_W'(MAZE_W);
    endfunction

    move_state_t       state;
    logic [9:0]        cand_x, cand_y;
    logic [WAIT_W-1:0] wait_cnt;
    logic              issue;
    logic [1:0]        dir;
    logic              at_edge;
    logic [9:0]        nx, ny;

    maze_key_repeat #(
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_key (
        .clk   (clk),
        .rst   (rst),
        .en    (state == S_IDLE),
        .mov   (mov),
        .issue (issue),
        .dir   (dir)
    );

    // Neighbour cell in the requested direction; at_edge flags moves that
    // would leave the board and are dropped without a ROM lookup.
    always_comb begin
        nx      = pos_x;
        ny      = pos_y;
        at_edge = 1'b0;
        case (dir)
            2'(DIR_UP): begin
                at_edge = (pos_y == 10'd0);
                ny      = pos_y - 10'd1;
            end
            2'(DIR_DOWN): begin
                at_edge = (pos_y == 10'(MAZE_H - 1));
                ny      = pos_y + 10'd1;
            end
            2'(DIR_LEFT): begin
                at_edge = (pos_x == 10'd0);
                nx      = pos_x - 10'd1;
            end
            default: begin
                at_edge = (pos_x == 10'(MAZE_W - 1));
                nx      = pos_x + 10'd1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            pos_x    <= START_XV;
            pos_y    <= START_YV;
            cand_x   <= 10'd0;
            cand_y   <= 10'd0;
            wait_cnt <= '0;
            rom_addr <= cell_addr(START_XV, START_YV);
            move_cnt <= 16'd0;
            running  <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue && !at_edge) begin
                        cand_x   <= nx;
                        cand_y   <= ny;
                        rom_addr <= cell_addr(nx, ny);
                        busy     <= 1'b1;
                        state    <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    wait_cnt <= '0;
                    state    <= (ROM_LAT > 1) ? S_WAIT : S_CHECK;
                end
                S_WAIT: begin
                    if (wait_cnt == WAIT_LAST) state <= S_CHECK;
                    else                       wait_cnt <= wait_cnt + 1'b1;
                end
                S_CHECK: begin
                    busy <= 1'b0;
                    if (rom_q) begin
                        // Wall: fall back to presenting the committed cell.
                        rom_addr <= cell_addr(pos_x, pos_y);
                        state    <= S_IDLE;
                    end else begin
                        // rom_addr already holds the candidate, which is now
                        // the committed cell.
                        pos_x <= cand_x;
                        pos_y <= cand_y;
                        if (move_cnt != 16'hFFFF) move_cnt <= move_cnt + 16'd1;
                        if (rom_addr == END_A) begin
                            running <= 1'b0;
                            done    <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            running <= 1'b1;
                            state   <= S_IDLE;
                        end
                    end
                end
                S_DONE: begin
                    running  <= 1'b0;
                    done     <= 1'b1;
                    rom_addr <= END_A;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_maze_move_ctrl.sv
// Bench for maze_move_ctrl: one instance with ROM_LAT=1 for the main
// function, repeat timing, random walks and the goal cell; a second with
// ROM_LAT=3 starting on the left edge for boundary, latency and mid-check
// reset. The wall map is a bench array behind delayed ROM models.
module tb_maze_move_ctrl;

    localparam int W     = 48;
    localparam int H     = 48;
    localparam int REP   = 8;
    localparam int END_A = 2110;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic [3:0]  mov_a, mov_b;
    logic [11:0] ra_a, ra_b;
    logic        q_a, q_b, qb1, qb2;
    logic [9:0]  x_a, y_a, x_b, y_b;
    logic [15:0] cnt_a, cnt_b;
    logic        run_a, run_b, done_a, done_b, busy_a, busy_b;

    logic        wall [0:4095];

    always @(posedge clk) q_a <= wall[ra_a];
    always @(posedge clk) begin
        qb1 <= wall[ra_b];
        qb2 <= qb1;
        q_b <= qb2;
    end

    maze_move_ctrl #(
        .MAZE_W(W), .MAZE_H(H), .ADDR_W(12), .START_X(1), .START_Y(1),
        .END_ADDR(END_A), .ROM_LAT(1), .REPEAT_CYCLES(REP)
    ) dut_a (
        .clk(clk), .rst(rst_a), .mov(mov_a), .rom_addr(ra_a), .rom_q(q_a),
        .pos_x(x_a), .pos_y(y_a), .move_cnt(cnt_a), .running(run_a),
        .done(done_a), .busy(busy_a)
    );

    maze_move_ctrl #(
        .MAZE_W(W), .MAZE_H(H), .ADDR_W(12), .START_X(0), .START_Y(1),
        .END_ADDR(END_A), .ROM_LAT(3), .REPEAT_CYCLES(REP)
    ) dut_b (
        .clk(clk), .rst(rst_b), .mov(mov_b), .rom_addr(ra_b), .rom_q(q_b),
        .pos_x(x_b), .pos_y(y_b), .move_cnt(cnt_b), .running(run_b),
        .done(done_b), .busy(busy_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_walls();
        for (int i = 0; i < 4096; i++) wall[i] = 1'b0;
    endtask

    // Behavioural model of the committed game state, one entry per move.
    int mx, my, mcnt;
    bit mrun, mdone;

    task automatic model_reset();
        mx = 1; my = 1; mcnt = 0; mrun = 0; mdone = 0;
    endtask

    task automatic model_step(input logic [3:0] m);
        int nx, ny, a;
        if (mdone || m == 4'd0) return;
        nx = mx;
        ny = my;
        if (m[0])      ny = ny - 1;
        else if (m[1]) ny = ny + 1;
        else if (m[2]) nx = nx - 1;
        else           nx = nx + 1;
        if (nx < 0 || ny < 0 || nx >= W || ny >= H) return;
        a = nx + ny * W;
        if (wall[a]) return;
        mx = nx;
        my = ny;
        mcnt++;
        if (a == END_A) begin
            mdone = 1;
            mrun  = 0;
        end else begin
            mrun = 1;
        end
    endtask

    task automatic reset_a();
        rst_a = 1'b1; mov_a = 4'd0;
        tick(); tick();
        rst_a = 1'b0;
        model_reset();
    endtask

    // One-cycle press, then settle past the commit and compare with the model.
    task automatic do_move(input logic [3:0] m, input string tag);
        model_step(m);
        mov_a = m;
        tick();
        mov_a = 4'd0;
        tick(); tick();
        chk({tag, " pos_x"},    x_a,    mx);
        chk({tag, " pos_y"},    y_a,    my);
        chk({tag, " move_cnt"}, cnt_a,  mcnt);
        chk({tag, " running"},  run_a,  int'(mrun));
        chk({tag, " done"},     done_a, int'(mdone));
        chk({tag, " busy"},     busy_a, 0);
        chk({tag, " rom_addr"}, ra_a,   mx + my * W);
    endtask

    // Move counter expected at cycle t when right is held for cycles 0..39:
    // an issue every REP idle cycles plus 1+ROM_LAT busy cycles, each commit
    // visible 3 cycles after its issue.
    function automatic int exp_rep(input int t);
        int n = 0;
        for (int s = 0; s < 40; s += REP + 2)
            if (s + 3 <= t) n++;
        return n;
    endfunction

    typedef struct {
        logic [3:0] mov;
        int         waddr;
        logic       wval;
        logic       busy1;
        int         ra1;
        int         x, y, cnt;
        logic       run;
        int         ra_end;
    } vec_t;

    vec_t vt [11];

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; mov_a = 4'd0; mov_b = 4'd0;
        clear_walls();

        vt[0]  = '{4'b1000, 50, 1'b1, 1'b1, 50, 1, 1, 0, 1'b0, 49};
        vt[1]  = '{4'b1000, 50, 1'b0, 1'b1, 50, 2, 1, 1, 1'b1, 50};
        vt[2]  = '{4'b0001,  2, 1'b0, 1'b1,  2, 2, 0, 2, 1'b1,  2};
        vt[3]  = '{4'b0001,  0, 1'b0, 1'b0,  2, 2, 0, 2, 1'b1,  2};
        vt[4]  = '{4'b0011,  0, 1'b0, 1'b0,  2, 2, 0, 2, 1'b1,  2};
        vt[5]  = '{4'b1110, 50, 1'b0, 1'b1, 50, 2, 1, 3, 1'b1, 50};
        vt[6]  = '{4'b1100, 49, 1'b0, 1'b1, 49, 1, 1, 4, 1'b1, 49};
        vt[7]  = '{4'b0100, 48, 1'b1, 1'b1, 48, 1, 1, 4, 1'b1, 49};
        vt[8]  = '{4'b0100, 48, 1'b0, 1'b1, 48, 0, 1, 5, 1'b1, 48};
        vt[9]  = '{4'b0100,  0, 1'b0, 1'b0, 48, 0, 1, 5, 1'b1, 48};
        vt[10] = '{4'b0010, 96, 1'b1, 1'b1, 96, 0, 1, 5, 1'b1, 48};

        // Reset state
        tick(); tick();
        rst_a = 1'b0; rst_b = 1'b0;
        model_reset();
        chk("rst pos_x",    x_a,    1);
        chk("rst pos_y",    y_a,    1);
        chk("rst rom_addr", ra_a,   49);
        chk("rst move_cnt", cnt_a,  0);
        chk("rst running",  run_a,  0);
        chk("rst done",     done_a, 0);
        chk("rst busy",     busy_a, 0);

        // Directed vectors: priority, walls, board edges
        for (int i = 0; i < 11; i++) begin
            wall[vt[i].waddr] = vt[i].wval;
            mov_a = vt[i].mov;
            tick();
            mov_a = 4'd0;
            chk($sformatf("vec%0d busy@1", i), busy_a, vt[i].busy1);
            chk($sformatf("vec%0d addr@1", i), ra_a,   vt[i].ra1);
            tick();
            chk($sformatf("vec%0d busy@2", i), busy_a, vt[i].busy1);
            tick();
            chk($sformatf("vec%0d pos_x", i),    x_a,    vt[i].x);
            chk($sformatf("vec%0d pos_y", i),    y_a,    vt[i].y);
            chk($sformatf("vec%0d move_cnt", i), cnt_a,  vt[i].cnt);
            chk($sformatf("vec%0d running", i),  run_a,  vt[i].run);
            chk($sformatf("vec%0d rom_addr", i), ra_a,   vt[i].ra_end);
            chk($sformatf("vec%0d busy@3", i),   busy_a, 0);
        end

        // Hold-to-repeat through a free corridor, then release
        clear_walls();
        reset_a();
        for (int t = 0; t <= 55; t++) begin
            mov_a = (t < 40) ? 4'b1000 : 4'b0000;
            chk($sformatf("repeat cnt@%0d", t), cnt_a, exp_rep(t));
            chk($sformatf("repeat x@%0d", t),   x_a,   1 + exp_rep(t));
            tick();
        end

        // Random presses over a random wall map
        reset_a();
        for (int i = 0; i < 4096; i++) wall[i] = ($urandom_range(0, 99) < 30);
        for (int i = 0; i < 200; i++)
            do_move(4'($urandom_range(1, 15)), $sformatf("rnd%0d", i));

        // Walk to the goal cell, then confirm the board is frozen
        clear_walls();
        reset_a();
        for (int i = 0; i < 45; i++) do_move(4'b1000, $sformatf("goal r%0d", i));
        for (int i = 0; i < 42; i++) do_move(4'b0010, $sformatf("goal d%0d", i));
        chk("goal done",     done_a, 1);
        chk("goal running",  run_a,  0);
        chk("goal rom_addr", ra_a,   END_A);
        do_move(4'b0001, "after done up");
        do_move(4'b0100, "after done left");
        mov_a = 4'b0001;
        for (int t = 0; t < 20; t++) begin
            tick();
            chk($sformatf("done hold busy@%0d", t), busy_a, 0);
        end
        mov_a = 4'd0;
        chk("done hold cnt", cnt_a, 87);

        // Second instance: left edge, 3-cycle ROM, reset mid-check
        clear_walls();
        rst_b = 1'b1; tick(); tick(); rst_b = 1'b0;
        chk("B rst rom_addr", ra_b,   48);
        chk("B rst pos_x",    x_b,    0);
        chk("B rst pos_y",    y_b,    1);
        chk("B rst busy",     busy_b, 0);
        chk("B rst done",     done_b, 0);

        mov_b = 4'b0100;
        for (int t = 1; t <= 4; t++) begin
            tick();
            mov_b = 4'd0;
            chk($sformatf("B edge busy@%0d", t), busy_b, 0);
            chk($sformatf("B edge addr@%0d", t), ra_b,   48);
        end
        chk("B edge pos_x", x_b, 0);

        mov_b = 4'b1000;
        tick();
        mov_b = 4'd0;
        for (int t = 1; t <= 6; t++) begin
            chk($sformatf("B lat busy@%0d", t), busy_b, (t <= 4) ? 1 : 0);
            chk($sformatf("B lat addr@%0d", t), ra_b,   49);
            chk($sformatf("B lat cnt@%0d", t),  cnt_b,  (t >= 5) ? 1 : 0);
            chk($sformatf("B lat x@%0d", t),    x_b,    (t >= 5) ? 1 : 0);
            tick();
        end
        chk("B lat running", run_b, 1);

        rst_b = 1'b1; tick(); tick(); rst_b = 1'b0;
        mov_b = 4'b1000;
        tick();
        mov_b = 4'd0;
        tick();
        chk("B wait busy", busy_b, 1);
        chk("B wait addr", ra_b,   49);
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        chk("B midrst busy",    busy_b, 0);
        chk("B midrst addr",    ra_b,   48);
        chk("B midrst pos_x",   x_b,    0);
        chk("B midrst cnt",     cnt_b,  0);
        chk("B midrst running", run_b,  0);
        for (int t = 0; t < 4; t++) tick();
        chk("B post pos_x",   x_b,    0);
        chk("B post cnt",     cnt_b,  0);
        chk("B post busy",    busy_b, 0);
        chk("B post running", run_b,  0);
        chk("B post addr",    ra_b,   48);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
